pll_dyn_ctrl: RTL
=================

# pll_dyn_ctrl

Parametrised dynamic-reconfiguration sequencer for a Gowin rPLL/PLLVR. It holds a table of NUM_PRESETS divider presets and accepts preset changes from a debounced push-key (step to the next preset) or a direct index request. It drives the PLL's inverted FDIV/IDIV inputs and reset, then waits for lock with timeout and retry. It sits between board inputs (key, host logic) and one PLL instance, replacing ad-hoc key-to-divider glue.

## Interface
Parameters:
- NUM_PRESETS, 2 — number of table entries (2..16).
- DIV_W, 6 — divider field width.
- FDIV_TABLE, {6'd12, 6'd9} — packed NUM_PRESETS×DIV_W plain (non-inverted) feedback dividers; entry 0 in the LSBs.
- IDIV_TABLE, {6'd5, 6'd2} — packed input dividers, same layout.
- DEBOUNCE_CYCLES, 16'd50000 — cycles the synchronised key must remain stable before it is accepted.
- RESET_CYCLES, 8'd16 — width of the pll_reset_o pulse per attempt.
- LOCK_STABLE, 8'd8 — consecutive synchronised lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 20'd100000 — cycles allowed in WAIT_LOCK per attempt.
- MAX_RETRIES, 2 — additional attempts after the first; FAULT is entered after these are exhausted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key  in  1  raw push-key, asynchronous to clk; active-high.
- sel_valid  in  1  direct preset request strobe.
- sel_idx  in  $clog2(NUM_PRESETS)  requested preset.
- lock_i  in  1  PLL lock, asynchronous to clk.
- pll_reset_o  out  1  PLL reset.
- fdiv_o  out  DIV_W  ~FDIV_TABLE[cur_idx].
- idiv_o  out  DIV_W  ~IDIV_TABLE[cur_idx].
- cur_idx  out  $clog2(NUM_PRESETS)  applied preset.
- busy  out  1  reconfiguration or relock in progress.
- locked  out  1  PLL locked at cur_idx.
- err  out  1  FAULT state.
- sel_rej  out  1  one-cycle pulse when sel_idx ≥ NUM_PRESETS.

## Operation
- lock_i and key each pass through a 2-FF synchroniser. The key is then debounced; a debounced 0→1 edge generates the request next = (cur_idx+1) mod NUM_PRESETS.
- sel_valid with a valid index generates the request sel_idx. If it coincides with a key edge, sel_valid wins and the key edge is dropped. An invalid index pulses sel_rej and is otherwise ignored.
- There is a single pending-request register; the last request wins. Requests accepted in any state are applied at the next IDLE or FAULT, and also immediately while in WAIT_LOCK.
- States:
  - HOLD_RST: pll_reset_o=1; counts RESET_CYCLES, then goes to WAIT_LOCK.
  - WAIT_LOCK: pll_reset_o=0; timeout counter runs.
    - LOCK_STABLE consecutive sync-lock-high cycles → IDLE.
    - Sync-lock low resets the stable count.
    - Timeout with retries remaining → HOLD_RST, retry count +1.
    - Timeout with retries exhausted → FAULT.
  - IDLE: locked=1, busy=0.
    - Pending request → APPLY.
    - Sync-lock low → WAIT_LOCK with the retry count cleared (no PLL reset).
  - APPLY: one cycle; cur_idx, fdiv_o and idiv_o update; retry count cleared; → HOLD_RST.
  - FAULT: err=1, pll_reset_o=0, busy=0. A pending request → APPLY and err clears. Lock alone does not exit FAULT.
- A request to the already-applied index is still executed as a full reconfiguration.
- Reset values: state HOLD_RST, cur_idx=0, fdiv_o=~FDIV_TABLE[0], idiv_o=~IDIV_TABLE[0], pll_reset_o=1, busy=1, locked=0, err=0, sel_rej=0, pending cleared, debouncer assumes key=0.
- Reset mid-operation aborts the sequence and restarts from preset 0.

## Timing
- All outputs are registered.
- sel_valid at cycle t while in IDLE:
  - APPLY at t+1; fdiv_o, idiv_o and cur_idx new at t+2.
  - pll_reset_o high for cycles t+2 … t+1+RESET_CYCLES.
- locked rises no earlier than 2 (sync) + LOCK_STABLE cycles after lock_i goes high in WAIT_LOCK.
- locked falls 3 cycles after lock_i falls while in IDLE.
- sel_rej is asserted in the cycle after the sel_valid strobe.
- Key latency is 2 + DEBOUNCE_CYCLES cycles to the request.
- Worst-case FAULT entry is (MAX_RETRIES+1)×(RESET_CYCLES+LOCK_TIMEOUT) cycles after APPLY.

## Structure
- Package pll_dyn_pkg holds the state enum (HOLD_RST, WAIT_LOCK, IDLE, APPLY, FAULT) and a function that extracts table entry i from a packed table.
- Sub-module key_debounce (2-FF synchroniser, stability counter, rising-edge pulse output) is reusable for the other board keys.

## Test plan
- Reset, lock_i high at cycle 5:
  - pll_reset_o high for 16 cycles.
  - fdiv_o=~9, idiv_o=~2.
  - locked=1 by cycle 16+2+8+margin.
  - busy=0.
- Key pressed for 60000 cycles, with 10 cycles of bounce at each edge:
  - exactly one request is generated.
  - cur_idx=1, fdiv_o=~12, idiv_o=~5.
  - a second press wraps back to cur_idx=0.
- sel_valid with sel_idx=3 at NUM_PRESETS=2 → sel_rej pulse; no state change.
- Two sel_valid strobes (idx 1, then 0) during HOLD_RST → only idx 0 is applied after lock.
- lock_i held low, LOCK_TIMEOUT=100:
  - exactly 3 reset pulses occur.
  - then err=1, busy=0.
  - a subsequent sel_valid clears err and restarts.
- In IDLE, drop lock_i for 5 cycles:
  - locked falls 3 cycles later.
  - no pll_reset_o pulse.
  - relock after LOCK_STABLE.
- Assert rst during WAIT_LOCK at cur_idx=1 → next cycle cur_idx=0, pll_reset_o=1.

Source files
------------

// File: rtl/pll_dyn_pkg.sv
// rtl/pll_dyn_pkg.sv - shared types and table helper for the PLL dynamic reconfiguration sequencer
package pll_dyn_pkg;

    typedef enum logic [2:0] {
        HOLD_RST,
        WAIT_LOCK,
        IDLE,
        APPLY,
        FAULT
    } state_t;

    localparam int MAX_DIV_W   = 16;
    localparam int MAX_PRESETS = 16;
    localparam int MAX_TABLE_W = MAX_DIV_W * MAX_PRESETS;

    // Entry idx of a packed table of w-bit fields, entry 0 in the LSBs.
    function automatic logic [MAX_DIV_W-1:0] table_entry(
        input logic [MAX_TABLE_W-1:0] tbl,
        input int                     idx,
        input int                     w
    );
        logic [MAX_DIV_W-1:0] mask;
        mask = (MAX_DIV_W'(1) << w) - MAX_DIV_W'(1);
        return MAX_DIV_W'(tbl >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/pll_dyn_ctrl_key_debounce.sv
// rtl/pll_dyn_ctrl_key_debounce.sv - key synchroniser and debouncer with rising-edge pulse
module key_debounce #(
    parameter logic [15:0] STABLE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic        key_m;
    logic        key_s;
    logic        key_db;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m  <= 1'b0;
            key_s  <= 1'b0;
            key_db <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            key_m <= key;
            key_s <= key_m;
            rise  <= 1'b0;
            if (key_s == key_db) begin
                cnt <= '0;
            end else if (({1'b0, cnt} + 17'd1) >= {1'b0, STABLE_CYCLES}) begin
                key_db <= key_s;
                cnt    <= '0;
                rise   <= key_s;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// rtl/pll_dyn_ctrl.sv - preset-table PLL reconfiguration sequencer with lock timeout and retry
module pll_dyn_ctrl #(
    parameter int                           NUM_PRESETS     = 2,
    parameter int                           DIV_W           = 6,
    parameter logic [NUM_PRESETS*DIV_W-1:0] FDIV_TABLE      = {6'd12, 6'd9},
    parameter logic [NUM_PRESETS*DIV_W-1:0] IDIV_TABLE      = {6'd5, 6'd2},
    parameter logic [15:0]                  DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]                   RESET_CYCLES    = 8'd16,
    parameter logic [7:0]                   LOCK_STABLE     = 8'd8,
    parameter logic [19:0]                  LOCK_TIMEOUT    = 20'd100000,
    parameter int                           MAX_RETRIES     = 2,
    localparam int                          IDX_W           = $clog2(NUM_PRESETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    input  logic             sel_valid,
    input  logic [IDX_W-1:0] sel_idx,
    input  logic             lock_i,
    output logic             pll_reset_o,
    output logic [DIV_W-1:0] fdiv_o,
    output logic [DIV_W-1:0] idiv_o,
    output logic [IDX_W-1:0] cur_idx,
    output logic             busy,
    output logic             locked,
    output logic             err,
    output logic             sel_rej
);

    import pll_dyn_pkg::*;

    state_t           state;
    state_t           next_state;
    logic             lock_m;
    logic             lock_s;
    logic             key_rise;
    logic             sel_ok;
    logic             sel_bad;
    logic [IDX_W-1:0] next_key_idx;
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             pend_valid;
    logic [IDX_W-1:0] pend_idx;
    logic             eff_valid;
    logic [IDX_W-1:0] eff_idx;
    logic [IDX_W-1:0] apply_idx;
    logic [19:0]      cnt;
    logic [7:0]       stab;
    logic [7:0]       retry;
    logic             hold_done;
    logic             timeout;
    logic             lock_done;
    logic             retry_left;
    logic             pll_reset_d;
    logic             busy_d;
    logic             locked_d;
    logic             err_d;

    key_debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk (clk),
        .rst (rst),
        .key (key),
        .rise(key_rise)
    );

    // A direct request beats a simultaneous key edge; a fresh request beats the stored one.
    always_comb begin
        sel_ok       = sel_valid && (int'(sel_idx) < NUM_PRESETS);
        sel_bad      = sel_valid && (int'(sel_idx) >= NUM_PRESETS);
        next_key_idx = (int'(cur_idx) >= NUM_PRESETS - 1) ? '0 : cur_idx + IDX_W'(1);
        req_valid    = sel_ok || key_rise;
        req_idx      = sel_ok ? sel_idx : next_key_idx;
        eff_valid    = req_valid || pend_valid;
        eff_idx      = req_valid ? req_idx : pend_idx;
        hold_done    = ({1'b0, cnt} + 21'd1) >= 21'(RESET_CYCLES);
        timeout      = ({1'b0, cnt} + 21'd1) >= 21'(LOCK_TIMEOUT);
        lock_done    = lock_s && (({1'b0, stab} + 9'd1) >= 9'(LOCK_STABLE));
        retry_left   = int'(retry) < MAX_RETRIES;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HOLD_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HOLD_RST: begin
                if (hold_done) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (eff_valid)      next_state = APPLY;
                else if (lock_done) next_state = IDLE;
                else if (timeout)   next_state = retry_left ? HOLD_RST : FAULT;
            end
            IDLE: begin
                if (eff_valid)    next_state = APPLY;
                else if (!lock_s) next_state = WAIT_LOCK;
            end
            APPLY:   next_state = HOLD_RST;
            FAULT: begin
                if (eff_valid) next_state = APPLY;
            end
            default: next_state = HOLD_RST;
        endcase
    end

    always_comb begin
        pll_reset_d = (next_state == HOLD_RST);
        busy_d      = !((next_state == IDLE) || (next_state == FAULT));
        locked_d    = (next_state == IDLE);
        err_d       = (next_state == FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m      <= 1'b0;
            lock_s      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_idx    <= '0;
            apply_idx   <= '0;
            cnt         <= '0;
            stab        <= '0;
            retry       <= '0;
            cur_idx     <= '0;
            fdiv_o      <= ~DIV_W'(table_entry(MAX_TABLE_W'(FDIV_TABLE), 0, DIV_W));
            idiv_o      <= ~DIV_W'(table_entry(MAX_TABLE_W'(IDIV_TABLE), 0, DIV_W));
            pll_reset_o <= 1'b1;
            busy        <= 1'b1;
            locked      <= 1'b0;
            err         <= 1'b0;
            sel_rej     <= 1'b0;
        end else begin
            lock_m <= lock_i;
            lock_s <= lock_m;

            if (next_state == APPLY) begin
                pend_valid <= 1'b0;
                apply_idx  <= eff_idx;
            end else begin
                pend_valid <= eff_valid;
                pend_idx   <= eff_idx;
            end

            // One counter serves both the reset pulse width and the lock timeout.
            if (next_state != state) begin
                cnt <= '0;
            end else if ((state == HOLD_RST) || (state == WAIT_LOCK)) begin
                cnt <= cnt + 20'd1;
            end

            if ((state == WAIT_LOCK) && (next_state == WAIT_LOCK) && lock_s) begin
                stab <= stab + 8'd1;
            end else begin
                stab <= '0;
            end

            if ((state == APPLY) || ((state == IDLE) && (next_state == WAIT_LOCK))) begin
                retry <= '0;
            end else if ((state == WAIT_LOCK) && (next_state == HOLD_RST)) begin
                retry <= retry + 8'd1;
            end

            if (state == APPLY) begin
                cur_idx <= apply_idx;
                fdiv_o  <= ~DIV_W'(table_entry(MAX_TABLE_W'(FDIV_TABLE), int'(apply_idx), DIV_W));
                idiv_o  <= ~DIV_W'(table_entry(MAX_TABLE_W'(IDIV_TABLE), int'(apply_idx), DIV_W));
            end

            pll_reset_o <= pll_reset_d;
            busy        <= busy_d;
            locked      <= locked_d;
            err         <= err_d;
            sel_rej     <= sel_bad;
        end
    end

endmodule
